data_mem_ctrl: RTL

Data-memory responder for the 16-bit core. It serves the execute stage's load, store, push and pop accesses on the mem_r_*/mem_w_* interface. Writes are posted into a small write buffer that drains to a single-port word RAM. Reads pass through a wait-state FSM and are forwarded from the write buffer when a buffered write hits the same address.

---
 rtl/data_mem_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data-memory responder with posted write buffer, read forwarding and wait-state read FSM
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1,
  parameter int WBUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_r_en,
  input  logic [15:0] mem_r_addr,
  output logic        mem_r_ready,
  output logic [15:0] mem_r_data,
  output logic        mem_r_valid,
  input  logic        mem_w_en,
  input  logic [15:0] mem_w_addr,
  input  logic [15:0] mem_w_data,
  output logic        mem_w_ready,
  output logic        mem_err
);

  localparam int              PW        = $clog2(WBUF_DEPTH);
  localparam int              CW        = PW + 1;
  localparam int              NWORDS    = 1 << ADDR_WIDTH;
  localparam logic [31:0]     ADDR_SPAN = 32'(NWORDS);
  // Address bits above the implemented array; any of them set means out of range.
  localparam logic [15:0]     HI_MASK   = 16'(~(ADDR_SPAN - 32'd1));
  localparam logic [CW-1:0]   FULL_CNT  = CW'(WBUF_DEPTH);
  localparam logic [2:0]      WS_LAST   = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    RESP      = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [15:0]           r_ram     [NWORDS];
  logic [ADDR_WIDTH-1:0] r_wb_addr [WBUF_DEPTH];
  logic [15:0]           r_wb_data [WBUF_DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [2:0]            r_wcnt;
  logic [15:0]           r_cap;
  logic [15:0]           r_rdata;
  logic                  r_valid;
  logic                  r_err;

  logic                  w_r_ready;
  logic                  w_r_acc;
  logic                  w_w_acc;
  logic                  w_r_oor;
  logic                  w_w_oor;
  logic                  w_push;
  logic                  w_drain;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_resp;
  logic                  w_fwd_hit;
  logic [15:0]           w_fwd_data;
  logic [15:0]           w_rd_word;
  logic [PW-1:0]         w_idx;
  logic [ADDR_WIDTH-1:0] w_r_word;
  logic [ADDR_WIDTH-1:0] w_w_word;

  assign w_r_word  = mem_r_addr[ADDR_WIDTH-1:0];
  assign w_w_word  = mem_w_addr[ADDR_WIDTH-1:0];
  assign w_r_oor   = |(mem_r_addr & HI_MASK);
  assign w_w_oor   = |(mem_w_addr & HI_MASK);

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_r_ready = (r_state == IDLE);
  assign w_r_acc   = mem_r_en & w_r_ready;
  // The array is single-ported: an accepted read owns it, so the drain waits.
  assign w_drain   = ~w_empty & ~w_r_acc;
  // A full buffer can still take a write on an edge where its head drains.
  assign mem_w_ready = ~w_full | w_drain;
  assign w_w_acc   = mem_w_en & mem_w_ready;
  // Out-of-range writes are acknowledged but never buffered.
  assign w_push    = w_w_acc & ~w_w_oor;

  assign mem_r_ready = w_r_ready;
  assign mem_r_data  = r_rdata;
  assign mem_r_valid = r_valid;
  assign mem_err     = r_err;

  // Search the buffer oldest to youngest so the youngest matching entry wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = 16'h0000;
    w_idx      = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_wb_addr[w_idx] == w_r_word)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wb_data[w_idx];
      end
    end
  end

  // Word returned by a read accepted this edge: same-edge write, then buffer, then array.
  always_comb begin
    w_rd_word = 16'h0000;
    if (w_r_oor) begin
      w_rd_word = 16'h0000;
    end else if (w_push && (w_w_word == w_r_word)) begin
      w_rd_word = mem_w_data;
    end else if (w_fwd_hit) begin
      w_rd_word = w_fwd_data;
    end else begin
      w_rd_word = r_ram[w_r_word];
    end
  end

  // Buffer payload storage; occupancy is tracked separately so this needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_tail] <= w_w_word;
      r_wb_data[r_tail] <= mem_w_data;
    end
  end

  // Drain the head entry into the array.
  always_ff @(posedge clk) begin
    if (w_drain) begin
      r_ram[r_wb_addr[r_head]] <= r_wb_data[r_head];
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_drain) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Read FSM next state; w_resp marks the cycle spent in RESP.
  always_comb begin
    w_next = r_state;
    w_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_r_en) begin
          w_next = (WAIT_STATES == 0) ? RESP : READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (r_wcnt == WS_LAST) begin
          w_next = RESP;
        end
      end
      RESP: begin
        w_resp = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Wait-state counter, cleared whenever the FSM is outside READ_WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt <= 3'd0;
    end else if (r_state != READ_WAIT) begin
      r_wcnt <= 3'd0;
    end else begin
      r_wcnt <= r_wcnt + 3'd1;
    end
  end

  // Capture at acceptance, publish on leaving RESP, flag out-of-range accesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cap   <= 16'h0000;
      r_rdata <= 16'h0000;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_r_acc) begin
        r_cap <= w_rd_word;
      end
      if (w_resp) begin
        r_rdata <= r_cap;
      end
      r_valid <= w_resp;
      r_err   <= (w_r_acc & w_r_oor) | (w_w_acc & w_w_oor);
    end
  end

endmodule
